// File: rtl/pll_pkg.sv
// Shared definitions for the PLL reference-frequency generator: FSM states and half-period type.
// N_BIT defaults to 16 unless the build defines it.
`ifndef N_BIT
`define N_BIT 16
`endif

package pll_pkg;
  localparam int N_BIT_DEF = `N_BIT;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  typedef logic [N_BIT_DEF-1:0] half_t;
endpackage

// File: rtl/ref_period_reg.sv
// Active/pending half-period register with valid/ready handshake.
// REF_FREQ_SWEEP_EN adds a saturating per-period sweep of the active value.
module ref_period_reg import pll_pkg::*; #(
  parameter int N_BIT = `N_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idle,
  input  logic             boundary,
`ifdef REF_FREQ_SWEEP_EN
  input  logic             to_high,
  input  logic [N_BIT-1:0] sweep_step,
  input  logic             sweep_up,
`endif
  input  logic [N_BIT-1:0] period_in,
  input  logic             period_valid,
  output logic             period_ready,
  output logic [N_BIT-1:0] period_d,
  output logic             written_q
);
  logic [N_BIT-1:0] act_q, pend_q, pend_d;
  logic             pend_full_q, pend_full_d, written_d, hs;

`ifdef REF_FREQ_SWEEP_EN
  function automatic logic [N_BIT-1:0] sweep_sat(input logic [N_BIT-1:0] v,
                                                 input logic [N_BIT-1:0] step,
                                                 input logic             up);
    logic [N_BIT:0] sum;
    sum = {1'b0, v} + {1'b0, step};
    if (up) begin
      if (sum[N_BIT]) return '1;
      if (sum[N_BIT-1:0] == '0) return N_BIT'(1);
      return sum[N_BIT-1:0];
    end
    if (v <= step) return N_BIT'(1);
    return v - step;
  endfunction
`endif

  assign period_ready = idle || !pend_full_q;
  assign hs           = period_valid && period_ready;

  always_comb begin
    period_d    = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    written_d   = written_q;
    if (idle) begin
      // A value stranded in pending when the wave stopped is promoted, unless a fresh load replaces it.
      if (hs) begin
        period_d    = period_in;
        written_d   = 1'b1;
        pend_full_d = 1'b0;
      end else if (pend_full_q) begin
        period_d    = pend_q;
        pend_full_d = 1'b0;
      end
    end else begin
      if (boundary && pend_full_q) begin
        period_d    = pend_q;
        pend_full_d = 1'b0;
      end
`ifdef REF_FREQ_SWEEP_EN
      else if (boundary && to_high) begin
        period_d = sweep_sat(act_q, sweep_step, sweep_up);
      end
`endif
      if (hs) begin
        pend_d      = period_in;
        pend_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      written_q   <= 1'b0;
    end else begin
      act_q       <= period_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      written_q   <= written_d;
    end
  end
endmodule

// File: rtl/ref_freq_gen.sv
// Square-wave reference generator: IDLE/HIGH/LOW FSM with a half-period down-counter.
// Optional macro REF_FREQ_SWEEP_EN exposes sweep_step/sweep_up for a per-period frequency sweep.
module ref_freq_gen import pll_pkg::*; #(
  parameter int N_BIT = `N_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_BIT-1:0] period_in,
  input  logic             period_valid,
  output logic             period_ready,
`ifdef REF_FREQ_SWEEP_EN
  input  logic [N_BIT-1:0] sweep_step,
  input  logic             sweep_up,
`endif
  output logic             freq_out,
  output logic             cycle_done,
  output logic             active
);
  state_t           state_q, state_d;
  logic [N_BIT-1:0] cnt_q, cnt_d, period_d, h_m1;
  logic             freq_out_q, freq_out_d, cycle_done_q, cycle_done_d;
  logic             active_q, active_d, written_q, boundary;

  assign boundary = (state_q == LOW) && (cnt_q == '0);
  // A zero half-period behaves as one cycle, so the counter reload never underflows.
  assign h_m1 = (period_d == '0) ? '0 : period_d - N_BIT'(1);

  ref_period_reg #(.N_BIT(N_BIT)) u_period (
    .clk          (clk),
    .rst          (rst),
    .idle         (state_q == IDLE),
    .boundary     (boundary),
`ifdef REF_FREQ_SWEEP_EN
    .to_high      (enable),
    .sweep_step   (sweep_step),
    .sweep_up     (sweep_up),
`endif
    .period_in    (period_in),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .period_d     (period_d),
    .written_q    (written_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (enable && written_q) begin
        state_d = HIGH;
        cnt_d   = h_m1;
      end
      HIGH: if (cnt_q == '0) begin
        state_d = LOW;
        cnt_d   = h_m1;
      end else begin
        cnt_d = cnt_q - N_BIT'(1);
      end
      LOW: if (cnt_q == '0) begin
        state_d = enable ? HIGH : IDLE;
        cnt_d   = enable ? h_m1 : '0;
      end else begin
        cnt_d = cnt_q - N_BIT'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    freq_out_d   = (state_d == HIGH);
    cycle_done_d = (state_d == LOW) && (cnt_d == '0);
    active_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      freq_out_q   <= 1'b0;
      cycle_done_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      freq_out_q   <= freq_out_d;
      cycle_done_q <= cycle_done_d;
      active_q     <= active_d;
    end
  end

  assign freq_out   = freq_out_q;
  assign cycle_done = cycle_done_q;
  assign active     = active_q;
endmodule
